// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment display arbiter slice.
package sseg_pkg;

  typedef logic [7:0] seg_pat_t;

  localparam seg_pat_t SSEG_BLANK = 8'hFF;
  localparam seg_pat_t AN_OFF     = 8'hFF;
  localparam seg_pat_t SEG_TOP    = 8'b10011100;
  localparam seg_pat_t SEG_BOT    = 8'b10100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sseg_scan.sv
// Digit-scan timebase: each digit is lit for SCAN_DIV cycles, frame_wrap marks 7->0.
import sseg_pkg::*;

module sseg_scan #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DIGITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] digit,
  output logic       frame_wrap
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             div_wrap;

  assign div_wrap   = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_wrap = div_wrap && (digit == 3'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div   <= '0;
      digit <= '0;
    end else if (div_wrap) begin
      div   <= '0;
      digit <= frame_wrap ? '0 : digit + 3'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner arbitration, shared frame buffer and registered scan outputs.
// Optional forced release after MAX_HOLD_FRAMES frames: define ARB_TIMEOUT_EN.
import sseg_pkg::*;

module sseg_display_arbiter #(
  parameter int unsigned SCAN_DIV        = 100000,
  parameter int unsigned DIGITS          = 8,
  parameter int unsigned MAX_HOLD_FRAMES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  output logic [1:0]      gnt,
  input  logic [1:0]      wr_en,
  input  logic [1:0][2:0] wr_addr,
  input  logic [1:0][7:0] wr_data,
  output logic            wr_err,
  output logic [7:0]      an,
  output logic [7:0]      sseg
);

  if (SCAN_DIV < 2 || DIGITS != 8 || MAX_HOLD_FRAMES < 1) begin : g_bad_params
    $error("sseg_display_arbiter: SCAN_DIV >= 2, DIGITS == 8, MAX_HOLD_FRAMES >= 1 required");
  end

  arb_state_t state, state_n;
  logic       last_owner;
  logic       enter_own;
  logic       force_rel;
  logic [2:0] digit;
  logic       frame_wrap;
  seg_pat_t   fb [DIGITS];

  sseg_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DIGITS   (DIGITS)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .digit      (digit),
    .frame_wrap (frame_wrap)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD_FRAMES + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_expired;

  // Held at zero while idle, so it starts fresh on every grant; saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (frame_wrap && !hold_expired) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD_FRAMES));
  assign force_rel    = hold_expired &&
                        (((state == OWN0) && req[1]) || ((state == OWN1) && req[0]));
`else
  logic wrap_unused;
  assign wrap_unused = frame_wrap;
  assign force_rel   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_n;
      if (state == OWN0 && state_n == IDLE) last_owner <= 1'b0;
      if (state == OWN1 && state_n == IDLE) last_owner <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req == 2'b01)      state_n = OWN0;
        else if (req == 2'b10) state_n = OWN1;
        else if (req == 2'b11) state_n = last_owner ? OWN0 : OWN1;
      end
      OWN0:    if (!req[0] || force_rel) state_n = IDLE;
      OWN1:    if (!req[1] || force_rel) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign enter_own = (state == IDLE) && (state_n != IDLE);

  always_comb begin
    gnt = '0;
    unique case (state)
      OWN0:    gnt = 2'b01;
      OWN1:    gnt = 2'b10;
      default: gnt = '0;
    endcase
  end

  // Grant entry blanks the buffer; gnt is still low on that edge, so no write can collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DIGITS; i++) fb[i] <= SSEG_BLANK;
    end else if (enter_own) begin
      for (int unsigned i = 0; i < DIGITS; i++) fb[i] <= SSEG_BLANK;
    end else begin
      if (gnt[0] && wr_en[0]) fb[wr_addr[0]] <= wr_data[0];
      if (gnt[1] && wr_en[1]) fb[wr_addr[1]] <= wr_data[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err <= 1'b0;
      an     <= AN_OFF;
      sseg   <= SSEG_BLANK;
    end else begin
      wr_err <= |(wr_en & ~gnt);
      if (gnt != '0) begin
        an   <= ~(8'd1 << digit);
        sseg <= fb[digit];
      end else begin
        an   <= AN_OFF;
        sseg <= SSEG_BLANK;
      end
    end
  end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench with a scoreboard queue of expected values for sseg_display_arbiter.
import sseg_pkg::*;

module tb_sseg_display_arbiter;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned MAXH     = 2;
  localparam int unsigned FRAME    = SCAN_DIV * 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req;
  logic [1:0]      gnt;
  logic [1:0]      wr_en;
  logic [1:0][2:0] wr_addr;
  logic [1:0][7:0] wr_data;
  logic            wr_err;
  logic [7:0]      an;
  logic [7:0]      sseg;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          edges = 0;
  logic [7:0]  exp_fb [8];

  sseg_display_arbiter #(
    .SCAN_DIV        (SCAN_DIV),
    .DIGITS          (8),
    .MAX_HOLD_FRAMES (MAXH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_err  (wr_err),
    .an      (an),
    .sseg    (sseg)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release: after k edges the lit digit is (k/SCAN_DIV)%8.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input logic [31:0] e);
    sbq.push_back('{tag: tag, exp: e});
  endtask

  task automatic check_val(input logic [31:0] obs);
    sb_t s;
    tests++;
    if (sbq.size() == 0) begin
      fails++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      s = sbq.pop_front();
      assert (obs === s.exp) else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(tag, e);
    check_val(obs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic blank_model();
    for (int i = 0; i < 8; i++) exp_fb[i] = SSEG_BLANK;
  endtask

  // Outputs lag the scan by one edge, so the digit shown is the one before the last edge.
  task automatic scan_check(input int n);
    int d;
    logic [7:0] one;
    for (int i = 0; i < n; i++) begin
      step();
      d   = ((edges - 1) / SCAN_DIV) % 8;
      one = 8'd1 << d;
      expect_val($sformatf("scan_an_d%0d", d), {24'd0, ~one});
      check_val({24'd0, an});
      expect_val($sformatf("scan_sseg_d%0d", d), {24'd0, exp_fb[d]});
      check_val({24'd0, sseg});
    end
  endtask

  initial begin
    int e0, w2, drop_at;
    rst     = 1'b0;
    req     = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    blank_model();
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_an", an, 8'hFF);
    chk("rst_sseg", sseg, 8'hFF);
    chk("rst_wr_err", wr_err, 0);
    rst = 1'b1;
    step();
    chk("idle_an", an, 8'hFF);

    // First grant: client 0 alone.
    req = 2'b01;
    chk("pre_grant_gnt", gnt, 0);
    step();
    chk("grant0_latency", gnt, 2'b01);
    blank_model();

    wr_en[0] = 1'b1; wr_addr[0] = 3'd3; wr_data[0] = 8'hA4;
    step();
    wr_en = '0;
    exp_fb[3] = 8'hA4;
    chk("owner_write_no_err", wr_err, 0);
    scan_check(36);

    // Non-granted client strobes: one-cycle error, buffer untouched.
    wr_en[1] = 1'b1; wr_addr[1] = 3'd3; wr_data[1] = 8'h00;
    step();
    wr_en = '0;
    chk("viol1_err_pulse", wr_err, 1);
    step();
    chk("viol1_err_clear", wr_err, 0);
    scan_check(34);

    // Consecutive writes to one address: last one wins.
    wr_en[0] = 1'b1; wr_addr[0] = 3'd5; wr_data[0] = 8'h11;
    step();
    wr_data[0] = 8'h22;
    step();
    wr_en = '0;
    exp_fb[5] = 8'h22;
    scan_check(34);

    // Handover: one idle cycle, then the waiter sees a blank buffer.
    req = 2'b11;
    step();
    chk("hold_while_other_waits", gnt, 2'b01);
    req = 2'b10;
    step();
    chk("handover_idle", gnt, 0);
    step();
    chk("handover_grant1", gnt, 2'b10);
    chk("handover_an_off", an, 8'hFF);
    chk("handover_sseg_off", sseg, 8'hFF);
    blank_model();
    scan_check(34);

    // Ties follow last_owner.
    req = 2'b00;
    step();
    chk("release1", gnt, 0);
    req = 2'b11;
    step();
    chk("tie_last1_to0", gnt, 2'b01);
    req = 2'b00;
    step();
    chk("release0", gnt, 0);
    req = 2'b11;
    step();
    chk("tie_last0_to1", gnt, 2'b10);
    req = 2'b10;
    step();
    chk("other_drop_no_effect", gnt, 2'b10);
    req = 2'b00;
    step();
    chk("release1_again", gnt, 0);

    // Both clients violate together: a single pulse.
    wr_en = 2'b11;
    step();
    wr_en = '0;
    chk("viol_both_pulse", wr_err, 1);
    step();
    chk("viol_both_clear", wr_err, 0);

    // Write presented on the grant-entry edge is dropped.
    req = 2'b01;
    wr_en[0] = 1'b1; wr_addr[0] = 3'd2; wr_data[0] = 8'h55;
    step();
    wr_en = '0;
    chk("entry_grant0", gnt, 2'b01);
    chk("entry_write_err", wr_err, 1);
    blank_model();
    scan_check(34);

    // Fresh grant for the hold-time test.
    req = 2'b00;
    step();
    chk("release_before_hold", gnt, 0);
    req = 2'b01;
    step();
    chk("hold_grant0", gnt, 2'b01);
    e0 = edges;
    req = 2'b11;
    drop_at = -1;
    for (int i = 0; i < 150; i++) begin
      step();
      if (gnt != 2'b01) begin
        drop_at = edges;
        break;
      end
    end
`ifdef ARB_TIMEOUT_EN
    w2 = (e0 / FRAME + 1) * FRAME + FRAME;
    chk("timeout_drop_edge", drop_at, w2 + 1);
    chk("timeout_idle", gnt, 0);
    step();
    chk("timeout_grant1", gnt, 2'b10);
    step();
    chk("timeout_keep1", gnt, 2'b10);
`else
    w2 = e0;
    chk("no_timeout_drop", drop_at, -1);
    chk("no_timeout_gnt", gnt, 2'b01);
`endif

    // Asynchronous reset mid-scan.
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_an", an, 8'hFF);
    chk("async_rst_sseg", sseg, 8'hFF);
    chk("async_rst_wr_err", wr_err, 0);
    req = 2'b00;
    #2;
    rst = 1'b1;
    step();
    chk("post_rst_no_grant", gnt, 0);
    chk("post_rst_an", an, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
